// File: rtl/i2c_single_reg_master.sv
// I2C initiator issuing one START / address+R/W / single data byte / STOP per command,
// driving an open-drain SCL/SDA pad pair and returning one response per command.
module i2c_single_reg_master #(
    parameter logic [15:0] PRESCALE = 16'd250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_read,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_valid,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP, RESP
    } state_t;

    state_t      state, state_next;
    logic        scl_m, scl_s, sda_m, sda_s;
    logic        scl_d1, scl_d2;
    logic [15:0] qcnt;
    logic [1:0]  quarter;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  wdata;
    logic        rd;
    logic        nack;

    logic        accept, in_bit, timing, stretch, q_end, last_q, phase_end, last_bit;

    assign accept    = cmd_valid && (state == IDLE);
    assign in_bit    = state inside {ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK};
    assign timing    = (state != IDLE) && (state != RESP);
    // scl_d2 tracks our own release through the same two-flop delay as the pad input,
    // so only a target genuinely holding SCL low counts as stretching.
    assign stretch   = (in_bit || state == STOP) && (quarter == 2'd2) && scl_d2 && !scl_s;
    assign q_end     = timing && !stretch && (qcnt == PRESCALE - 16'd1);
    assign last_q    = (state == START) ? (quarter == 2'd1) : (quarter == 2'd3);
    assign phase_end = q_end && last_q;
    assign last_bit  = (bit_cnt == 3'd7);

    assign scl_o = scl_t;
    assign sda_o = sda_t;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        scl_t      = 1'b1;
        sda_t      = 1'b1;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) state_next = START;
            end
            START: begin
                sda_t = (quarter == 2'd0);
                if (phase_end) state_next = ADDR;
            end
            ADDR: begin
                scl_t = quarter[1];
                sda_t = shift[7];
                if (phase_end && last_bit) state_next = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_t = quarter[1];
                if (phase_end) begin
                    if (sda_s)   state_next = STOP;
                    else if (rd) state_next = READ;
                    else         state_next = WRITE;
                end
            end
            WRITE: begin
                scl_t = quarter[1];
                sda_t = shift[7];
                if (phase_end && last_bit) state_next = WRITE_ACK;
            end
            WRITE_ACK: begin
                scl_t = quarter[1];
                if (phase_end) state_next = STOP;
            end
            READ: begin
                scl_t = quarter[1];
                if (phase_end && last_bit) state_next = READ_NACK;
            end
            READ_NACK: begin
                scl_t = quarter[1];
                if (phase_end) state_next = STOP;
            end
            STOP: begin
                scl_t = quarter[1];
                sda_t = (quarter == 2'd3);
                if (phase_end) state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m    <= 1'b1;
            scl_s    <= 1'b1;
            sda_m    <= 1'b1;
            sda_s    <= 1'b1;
            scl_d1   <= 1'b1;
            scl_d2   <= 1'b1;
            qcnt     <= '0;
            quarter  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            wdata    <= '0;
            rd       <= 1'b0;
            nack     <= 1'b0;
            rsp_data <= '0;
            rsp_nack <= 1'b0;
        end else begin
            scl_m  <= scl_i;
            scl_s  <= scl_m;
            sda_m  <= sda_i;
            sda_s  <= sda_m;
            scl_d1 <= scl_t;
            scl_d2 <= scl_d1;

            if (!timing || stretch) begin
                qcnt <= '0;
                if (!timing) quarter <= '0;
            end else if (q_end) begin
                qcnt    <= '0;
                quarter <= last_q ? 2'd0 : quarter + 2'd1;
            end else begin
                qcnt <= qcnt + 16'd1;
            end

            if (accept) begin
                wdata   <= cmd_data;
                rd      <= cmd_read;
                shift   <= {cmd_addr, cmd_read};
                nack    <= 1'b0;
                bit_cnt <= '0;
            end else if (phase_end) begin
                case (state)
                    ADDR, WRITE: begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    READ: begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ADDR_ACK: begin
                        if (sda_s) nack <= 1'b1;
                        else       shift <= wdata;
                    end
                    WRITE_ACK: nack <= sda_s;
                    STOP: begin
                        rsp_data <= (rd && !nack) ? shift : 8'h00;
                        rsp_nack <= nack;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_single_reg_master.md
# i2c_single_reg_master

I2C controller (bus initiator) for single-byte register-less transactions: one START, a 7-bit address plus R/W bit, one data byte written or read, then STOP. It drives an external open-drain pad pair and accepts one command at a time over a valid/ready handshake. It returns one response per command. It is the initiator-side counterpart of the team's single-register I2C target and is used to configure and poll simple byte-wide I2C devices from fabric logic.

## Interface
Parameters:
- PRESCALE, 16'd250: clk cycles per SCL quarter period; legal range 2..65535.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- scl_i  input  1  SCL pad input.
- scl_o  output  1  SCL output value; equal to scl_t.
- scl_t  output  1  SCL tristate; 1 = released (high), 0 = driven low.
- sda_i  input  1  SDA pad input.
- sda_o  output  1  SDA output value; equal to sda_t.
- sda_t  output  1  SDA tristate; 1 = released, 0 = driven low.
- cmd_addr  input  7  target device address.
- cmd_read  input  1  1 = read transaction, 0 = write transaction.
- cmd_data  input  8  byte to write; ignored for reads.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- rsp_data  output  8  byte read; 8'h00 for writes or on NACK.
- rsp_nack  output  1  1 = address or write-data byte was NACKed.
- rsp_valid  output  1  single-cycle response strobe.
- busy  output  1  high from command accept until rsp_valid.

## Operation
- Inputs scl_i and sda_i pass through a 2-flop synchronizer. All sampling uses the synchronized values.
- Quarter timer: counts PRESCALE cycles; each expiry ends one quarter.
- Command accept: cmd_valid && cmd_ready. On accept, latch addr, read, data, and set shift = {addr, read}.
- States:
  - IDLE: both lines released; cmd_ready=1. Accept moves to START.
  - START: 2 quarters. Q0: both released. Q1: SDA low, SCL released. Then go to ADDR.
  - ADDR: 8 bits, MSB first.
  - ADDR_ACK: 1 bit; SDA released.
    - Sampled 1: set nack and go to STOP.
    - Sampled 0: go to WRITE (cmd_read=0) or READ (cmd_read=1).
  - WRITE: 8 bits of cmd_data, MSB first.
  - WRITE_ACK: 1 bit; SDA released; nack = sampled value. Then go to STOP.
  - READ: 8 bits; SDA released; shift in sampled bits, MSB first.
  - READ_NACK: 1 bit; SDA released, so the controller always NACKs the single read byte. Then go to STOP.
  - STOP: 4 quarters.
    - Q0 and Q1: SCL low, SDA low.
    - Q2: SCL released, SDA low.
    - Q3: SCL released, SDA released.
    - Then go to RESP.
  - RESP: 1 cycle. rsp_valid=1; rsp_data = read byte (or 8'h00); rsp_nack. Then go to IDLE.
- Bit slot: 4 quarters.
  - Q0: SCL low; update SDA on the first cycle of Q0.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL released.
  - Sample SDA on the final cycle of Q3.
- Clock stretching: in Q2 of any bit slot and in STOP Q2, the quarter timer is held at 0 while synchronized SCL is 0. It starts counting on the first cycle SCL reads 1. No timeout.
- Not supported: multi-master arbitration, repeated START, multi-byte transfers. SDA mismatch while releasing is ignored.
- rsp_data and rsp_nack hold their values until the next RESP.

## Timing
- Reset values:
  - scl_t=scl_o=1, sda_t=sda_o=1.
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_nack=0, rsp_data=8'h00.
  - State is IDLE.
- Reset mid-transaction: lines are released on the cycle after rst is sampled. No STOP is generated. No response is issued.
- Accept to first quarter: START Q0 begins the cycle after accept.
- Durations without stretching, from accept to the rsp_valid cycle inclusive:
  - Write, ACKed: (2+36+36+4)×PRESCALE + 1 = 78×PRESCALE + 1 cycles.
  - Read: 78×PRESCALE + 1 cycles.
  - Address NACK: 42×PRESCALE + 1 cycles.
- Each stretch cycle adds exactly one cycle, plus the 2-cycle synchronizer latency once per stretch event.
- cmd_valid while busy: ignored. The command is not latched and cmd_ready stays 0.
- cmd_valid held across RESP: the next accept happens in the first IDLE cycle after RESP.
- SCL frequency = clk / (4×PRESCALE).

## Test plan
- Write, acknowledged: PRESCALE=4, addr 7'h70, data 8'hA5, target model ACKs.
  - Required: SDA bit sequence 1110000_0, then ACK slot, then 10100101, then ACK slot.
  - Required: rsp_valid at cycle 78×4+1 after accept, rsp_nack=0, rsp_data=8'h00.
- Read: addr 7'h70, read=1, model returns 8'h3C.
  - Required: rsp_data=8'h3C, rsp_nack=0, SDA released during the 9th data slot.
  - Required: STOP observed, i.e. SDA rises while SCL is high.
- Address NACK: no target present (SDA stays high).
  - Required: STOP follows the address ACK slot directly.
  - Required: rsp_nack=1, rsp_valid at cycle 42×PRESCALE+1.
- Clock stretching: model holds SCL low for 50 cycles in the address ACK slot.
  - Required: completion is delayed by exactly 50 + 2 cycles.
  - Required: no SCL high quarter is shorter than PRESCALE.
- Busy and reset: a second cmd_valid during a write is ignored, with cmd_ready=0 throughout.
  - Required on rst in the middle of the WRITE state: scl_t=sda_t=1 on the next cycle, no rsp_valid, cmd_ready=1.
  - Required: a following command completes normally.
